opl3_host_if: RTL and testbench

OPL3_HOST_IF -- requirements
Module: opl3_host_if

---
 rtl/opl3_host_if.sv | 123 ++++++++++++
 tb/tb_opl3_host_if.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opl3_host_if.sv
// OPL3 host bus front end: per-bank address latches, a small write FIFO and
// a pacing counter that spaces register writes toward the OPL3 register file.
package opl3_host_if_pkg;
   typedef struct packed {
      logic       valid;
      logic       bank_num;
      logic [7:0] address;
      logic [7:0] data;
   } opl3_reg_wr_t;
endpackage

module opl3_host_if
   import opl3_host_if_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MIN_WR_GAP = 36
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         host_valid,
   output logic         host_ready,
   input  logic [1:0]   host_addr,
   input  logic [7:0]   host_data,
   output opl3_reg_wr_t opl3_reg_wr,
   output logic         busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int GAP_W = (MIN_WR_GAP > 1) ? $clog2(MIN_WR_GAP) : 1;

   typedef struct packed {
      logic       bank;
      logic [7:0] addr;
      logic [7:0] data;
   } entry_t;

   logic [1:0][7:0]            latch_q, latch_d;
   entry_t [FIFO_DEPTH-1:0]    mem_q, mem_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic [GAP_W-1:0]           gap_q, gap_d;
   opl3_reg_wr_t               reg_wr_q, reg_wr_d;

   logic full;
   logic accept;
   logic push;
   logic pop;

   // Ready depends only on registered occupancy, so a same-cycle pop never
   // reopens the port while the FIFO is full.
   always_comb begin
      full   = (count_q == CNT_W'(FIFO_DEPTH));
      accept = host_valid & ~full;
      push   = accept & host_addr[0];
      pop    = (count_q != '0) && (gap_q == '0);

      latch_d = latch_q;
      if (accept && !host_addr[0]) begin
         latch_d[host_addr[1]] = host_data;
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{bank: host_addr[1], addr: latch_q[host_addr[1]], data: host_data};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end

      if (pop) begin
         gap_d = GAP_W'(MIN_WR_GAP - 1);
      end else if (gap_q != '0) begin
         gap_d = gap_q - GAP_W'(1);
      end else begin
         gap_d = '0;
      end

      // Payload fields hold their last value; only valid pulses.
      reg_wr_d       = reg_wr_q;
      reg_wr_d.valid = 1'b0;
      if (pop) begin
         reg_wr_d = '{valid:    1'b1,
                      bank_num: mem_q[rd_ptr_q].bank,
                      address:  mem_q[rd_ptr_q].addr,
                      data:     mem_q[rd_ptr_q].data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_q  <= '0;
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         gap_q    <= '0;
         reg_wr_q <= '0;
      end else begin
         latch_q  <= latch_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
         reg_wr_q <= reg_wr_d;
      end
   end

   assign host_ready  = ~full;
   assign opl3_reg_wr = reg_wr_q;
   assign busy        = (count_q != '0) | (gap_q != '0) | reg_wr_q.valid;

endmodule

// File: tb/tb_opl3_host_if.sv
// Directed bench for opl3_host_if: a host-side model fills a scoreboard queue
// and negedge monitors pop it on every emitted register write.
module tb_opl3_host_if;
   import opl3_host_if_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         host_valid = 1'b0;
   logic [1:0]   host_addr = '0;
   logic [7:0]   host_data = '0;
   logic         host_ready;
   opl3_reg_wr_t reg_wr;
   logic         busy;

   logic         f_host_valid = 1'b0;
   logic [1:0]   f_host_addr = '0;
   logic [7:0]   f_host_data = '0;
   logic         f_host_ready;
   opl3_reg_wr_t f_reg_wr;
   logic         f_busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0]   latch_m [2];
   logic [7:0]   f_latch_m [2];
   opl3_reg_wr_t exp_q [$];
   opl3_reg_wr_t f_exp_q [$];
   int           pulse_q [$];
   int           f_pulse_q [$];

   opl3_host_if #(.FIFO_DEPTH(4), .MIN_WR_GAP(36)) dut (
      .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(host_ready),
      .host_addr(host_addr), .host_data(host_data), .opl3_reg_wr(reg_wr), .busy(busy)
   );

   opl3_host_if #(.FIFO_DEPTH(4), .MIN_WR_GAP(1)) dut_fast (
      .clk(clk), .rst_n(rst_n), .host_valid(f_host_valid), .host_ready(f_host_ready),
      .host_addr(f_host_addr), .host_data(f_host_data), .opl3_reg_wr(f_reg_wr), .busy(f_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic opl3_reg_wr_t mk(input logic b, input logic [7:0] a, input logic [7:0] d);
      return opl3_reg_wr_t'{valid: 1'b1, bank_num: b, address: a, data: d};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitors: every pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (reg_wr.valid) begin
         pulse_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            check_output("unexpected_pulse", 32'(reg_wr), 32'h0);
         end else begin
            check_output("pulse", 32'(reg_wr), 32'(exp_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (f_reg_wr.valid) begin
         f_pulse_q.push_back(cyc);
         if (f_exp_q.size() == 0) begin
            check_output("fast_unexpected_pulse", 32'(f_reg_wr), 32'h0);
         end else begin
            check_output("fast_pulse", 32'(f_reg_wr), 32'(f_exp_q.pop_front()));
         end
      end
   end

   task automatic apply_stimulus(input bit fast, input logic [1:0] a, input logic [7:0] d,
                                 output bit acc, output int acc_cyc);
      @(negedge clk);
      acc_cyc = cyc;
      if (fast) begin
         f_host_valid = 1'b1; f_host_addr = a; f_host_data = d;
         acc = f_host_ready;
         if (acc) begin
            if (!a[0]) f_latch_m[a[1]] = d;
            else f_exp_q.push_back(mk(a[1], f_latch_m[a[1]], d));
         end
      end else begin
         host_valid = 1'b1; host_addr = a; host_data = d;
         acc = host_ready;
         if (acc) begin
            if (!a[0]) latch_m[a[1]] = d;
            else exp_q.push_back(mk(a[1], latch_m[a[1]], d));
         end
      end
      @(posedge clk);
   endtask

   task automatic host_idle();
      @(negedge clk);
      host_valid = 1'b0;
      f_host_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit fast, input int max_cycles, output int fall_cyc);
      fall_cyc = -1;
      for (int i = 0; i < max_cycles; i++) begin
         if ((fast ? f_busy : busy) == 1'b0) begin
            fall_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (fall_cyc < 0) check_output("idle_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit acc;
      int ac, fall, p0, n_acc, before_drop, first_acc, tries;
      int acc_cyc [10];
      bit acc_ok [10];

      latch_m = '{8'h00, 8'h00};
      f_latch_m = '{8'h00, 8'h00};

      // Reset state, during and after reset
      repeat (3) @(negedge clk);
      check_output("rst_ready", 32'(host_ready), 32'h1);
      check_output("rst_busy", 32'(busy), 32'h0);
      check_output("rst_reg_wr", 32'(reg_wr), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("post_rst_ready", 32'(host_ready), 32'h1);
      check_output("post_rst_busy", 32'(busy), 32'h0);
      check_output("post_rst_reg_wr", 32'(reg_wr), 32'h0);
      check_output("post_rst_fast_reg_wr", 32'(f_reg_wr), 32'h0);

      // Basic write: address 0x20 then data 0x21
      p0 = pulse_q.size();
      apply_stimulus(0, 2'd0, 8'h20, acc, ac);
      apply_stimulus(0, 2'd1, 8'h21, acc, ac);
      host_idle();
      wait_idle(0, 200, fall);
      check_output("basic_count", 32'(pulse_q.size() - p0), 32'd1);
      if (pulse_q.size() > p0) begin
         check_output("basic_latency", 32'(pulse_q[p0]), 32'(ac + 2));
         check_output("basic_busy_fall", 32'(fall), 32'(pulse_q[p0] + 35));
      end
      check_output("basic_hold", 32'(reg_wr), 32'(opl3_reg_wr_t'{1'b0, 1'b0, 8'h20, 8'h21}));

      // Bank separation
      p0 = pulse_q.size();
      apply_stimulus(0, 2'd2, 8'h05, acc, ac);
      apply_stimulus(0, 2'd0, 8'hB0, acc, ac);
      apply_stimulus(0, 2'd3, 8'h01, acc, ac);
      host_idle();
      wait_idle(0, 200, fall);
      check_output("bank_count", 32'(pulse_q.size() - p0), 32'd1);
      check_output("bank_hold", 32'(reg_wr), 32'(opl3_reg_wr_t'{1'b0, 1'b1, 8'h05, 8'h01}));

      // Burst of 6 data writes into a 4-deep FIFO
      p0 = pulse_q.size();
      n_acc = 0; before_drop = -1; first_acc = 0; tries = 0;
      while (n_acc < 6 && tries < 400) begin
         apply_stimulus(0, 2'd1, 8'(n_acc), acc, ac);
         if (acc) begin
            if (n_acc == 0) first_acc = ac;
            n_acc++;
         end else if (before_drop < 0) begin
            before_drop = n_acc;
         end
         tries++;
      end
      host_idle();
      wait_idle(0, 600, fall);
      check_output("burst_accepted", 32'(n_acc), 32'd6);
      check_output("burst_before_drop", 32'(before_drop), 32'd5);
      check_output("burst_count", 32'(pulse_q.size() - p0), 32'd6);
      if (pulse_q.size() - p0 == 6) begin
         check_output("burst_first_latency", 32'(pulse_q[p0]), 32'(first_acc + 2));
         for (int i = 1; i < 6; i++)
            check_output("burst_spacing", 32'(pulse_q[p0 + i] - pulse_q[p0 + i - 1]), 32'd36);
         check_output("burst_busy_fall", 32'(fall), 32'(pulse_q[p0 + 5] + 35));
      end
      check_output("burst_drained", 32'(exp_q.size()), 32'd0);

      // Reset with writes still queued
      apply_stimulus(0, 2'd0, 8'h33, acc, ac);
      for (int i = 0; i < 4; i++) apply_stimulus(0, 2'd1, 8'(8'h60 + i), acc, ac);
      @(negedge clk);
      host_valid = 1'b0;
      check_output("midrst_busy_before", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      f_exp_q.delete();
      latch_m = '{8'h00, 8'h00};
      f_latch_m = '{8'h00, 8'h00};
      #1;
      check_output("midrst_reg_wr", 32'(reg_wr), 32'h0);
      check_output("midrst_busy", 32'(busy), 32'h0);
      check_output("midrst_ready", 32'(host_ready), 32'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      p0 = pulse_q.size();
      repeat (100) @(negedge clk);
      check_output("midrst_silent", 32'(pulse_q.size() - p0), 32'd0);
      apply_stimulus(0, 2'd1, 8'h77, acc, ac);
      host_idle();
      wait_idle(0, 200, fall);
      check_output("midrst_new_count", 32'(pulse_q.size() - p0), 32'd1);
      check_output("midrst_addr0", 32'(reg_wr), 32'(opl3_reg_wr_t'{1'b0, 1'b0, 8'h00, 8'h77}));

      // MIN_WR_GAP=1: continuous data writes stream straight through
      apply_stimulus(1, 2'd2, 8'h10, acc, ac);
      p0 = f_pulse_q.size();
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1, 2'd3, 8'(8'hA0 + i), acc, ac);
         acc_ok[i] = acc;
         acc_cyc[i] = ac;
      end
      host_idle();
      wait_idle(1, 50, fall);
      for (int i = 0; i < 10; i++) check_output("fast_ready", 32'(acc_ok[i]), 32'h1);
      check_output("fast_count", 32'(f_pulse_q.size() - p0), 32'd10);
      if (f_pulse_q.size() - p0 == 10) begin
         for (int i = 0; i < 10; i++)
            check_output("fast_timing", 32'(f_pulse_q[p0 + i]), 32'(acc_cyc[i] + 2));
      end
      check_output("fast_drained", 32'(f_exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
